// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter: round-robin merge of local single-flit sources into a FIFO feeding one spine leaf port
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   src_data          flit of source i at [i*DWIDTH +: DWIDTH]
//   src_valid         per-source offer
//   src_ready         one-hot grant, accept when src_valid[i] & src_ready[i]
//   uplink_full       spine input FIFO full, blocks issue
//   uplink_data       flit toward spine, held while uplink_valid is low
//   uplink_valid      one-cycle strobe per flit
//   fifo_count        uplink FIFO occupancy
//   stat_flits        (UPLINK_STATS_EN) saturating 16-bit accepted-flit counter per source
//   stat_stall_cycles (UPLINK_STATS_EN) saturating count of cycles with data queued but spine full
module leaf_uplink_arbiter #(
    parameter logic [3:0] GROUP_ID   = 4'b0110,
    parameter int         NUM_SRC    = 4,
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DWIDTH-1:0]     src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          uplink_full,
    output logic [DWIDTH-1:0]             uplink_data,
    output logic                          uplink_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UPLINK_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]         stat_flits,
    output logic [15:0]                   stat_stall_cycles
`endif
);
    localparam int PW = $clog2(NUM_SRC);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [PW-1:0]     rr_ptr, win;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [0:0]        state;
    logic              hit, pop, full;
    // group id only travels with the block for header checks upstream
    logic              unused_group;

    assign unused_group = ^GROUP_ID;
    assign full         = fifo_count == CW'(FIFO_DEPTH);
    assign pop          = fifo_count != '0 && !uplink_full;
    assign uplink_valid = state == SEND;

    // walk downward so the source closest to rr_ptr is the last to overwrite win
    always_comb begin
        win = rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (src_valid[(int'(rr_ptr) + k) % NUM_SRC]) win = PW'((int'(rr_ptr) + k) % NUM_SRC);
        hit       = |src_valid && !full && !reset;
        src_ready = hit ? NUM_SRC'(1) << win : '0;
    end

    always_ff @(posedge clk)
        if (hit) mem[wr_ptr] <= src_data[int'(win)*DWIDTH +: DWIDTH];

    // the output FSM reduces to "SEND next cycle iff a pop happens now"
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            state       <= IDLE;
            uplink_data <= '0;
        end else begin
            if (hit) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= win == PW'(NUM_SRC - 1) ? '0 : win + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                uplink_data <= mem[rd_ptr];
            end
            fifo_count <= fifo_count + CW'(hit) - CW'(pop);
            state      <= pop ? SEND : IDLE;
        end
    end

`ifdef UPLINK_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flits        <= '0;
            stat_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (hit && win == PW'(i) && stat_flits[i*16 +: 16] != 16'hFFFF)
                    stat_flits[i*16 +: 16] <= stat_flits[i*16 +: 16] + 16'd1;
            if (fifo_count != '0 && uplink_full && stat_stall_cycles != 16'hFFFF)
                stat_stall_cycles <= stat_stall_cycles + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// tb_leaf_uplink_arbiter: directed checks of arbitration, FIFO, output timing and reset
module tb_leaf_uplink_arbiter;
    logic        clk, reset, uplink_full, uplink_valid;
    logic [63:0] src_data;
    logic [3:0]  src_valid, src_ready, fifo_count;
    logic [15:0] uplink_data;
    int          vectors, errors;
`ifdef UPLINK_STATS_EN
    logic [63:0] stat_flits;
    logic [15:0] stat_stall_cycles;
`endif

    leaf_uplink_arbiter dut (
        .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .uplink_full(uplink_full), .uplink_data(uplink_data),
        .uplink_valid(uplink_valid), .fifo_count(fifo_count)
`ifdef UPLINK_STATS_EN
        , .stat_flits(stat_flits), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    initial begin
        vectors = 0; errors = 0;
        reset = 1; uplink_full = 0; src_valid = 4'hF; src_data = '0;
        repeat (2) tick;
        check("rst_ready", 32'(src_ready), 32'h0);
        check("rst_valid", 32'(uplink_valid), 32'h0);
        check("rst_data", 32'(uplink_data), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        src_valid = 0; reset = 0;
        tick;
        // single flit latency
        src_valid = 4'b0001; src_data[15:0] = 16'hA5C3; #1;
        check("t1_ready", 32'(src_ready), 32'h1);
        tick; src_valid = 0; #1;
        check("t1_n1_valid", 32'(uplink_valid), 32'h0);
        check("t1_n1_count", 32'(fifo_count), 32'h1);
        tick;
        check("t1_n2_valid", 32'(uplink_valid), 32'h1);
        check("t1_n2_data", 32'(uplink_data), 32'hA5C3);
        tick;
        check("t1_n3_valid", 32'(uplink_valid), 32'h0);
        check("t1_n3_hold", 32'(uplink_data), 32'hA5C3);
        // round robin, all sources
        reset = 1; tick; reset = 0;
        src_data = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00}; src_valid = 4'hF; #1;
        for (int k = 0; k < 8; k++) begin
            check("t2_grant", 32'(src_ready), 32'(1) << (k % 4));
            if (k >= 2) begin
                check("t2_valid", 32'(uplink_valid), 32'h1);
                check("t2_data", 32'(uplink_data), 32'h0A00 + 32'((k - 2) % 4));
            end
            tick;
        end
        src_valid = 0;
        repeat (3) tick;
        check("t2_drain_count", 32'(fifo_count), 32'h0);
        check("t2_drain_valid", 32'(uplink_valid), 32'h0);
        // fill under backpressure, then drain in order
        uplink_full = 1; src_valid = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            src_data[31:16] = 16'hB000 + 16'(k); #1;
            check("t3_grant", 32'(src_ready), 32'h2);
            check("t3_count", 32'(fifo_count), 32'(k));
            tick;
        end
        check("t3_full_ready", 32'(src_ready), 32'h0);
        check("t3_full_count", 32'(fifo_count), 32'h8);
        check("t3_stall_valid", 32'(uplink_valid), 32'h0);
        check("t3_stall_hold", 32'(uplink_data), 32'h0A03);
        tick;
        uplink_full = 0; #1;
        check("t3_pop_noGrant", 32'(src_ready), 32'h0);
        check("t3_pop_count", 32'(fifo_count), 32'h8);
        tick;
        src_valid = 0; #1;
        check("t3_after_count", 32'(fifo_count), 32'h7);
        for (int j = 0; j < 8; j++) begin
            check("t3_b2b_valid", 32'(uplink_valid), 32'h1);
            check("t3_b2b_data", 32'(uplink_data), 32'hB000 + 32'(j));
            tick;
        end
        check("t3_end_valid", 32'(uplink_valid), 32'h0);
        check("t3_end_count", 32'(fifo_count), 32'h0);
        // push+pop at count 3 (rr_ptr is 2, only src0 offers)
        uplink_full = 1; src_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            src_data[15:0] = 16'hC000 + 16'(k); #1;
            check("t4_grant", 32'(src_ready), 32'h1);
            tick;
        end
        uplink_full = 0; src_data[15:0] = 16'hC003; #1;
        check("t4_pp_grant", 32'(src_ready), 32'h1);
        check("t4_pp_count", 32'(fifo_count), 32'h3);
        tick;
        src_valid = 0; #1;
        check("t4_keep_count", 32'(fifo_count), 32'h3);
        for (int j = 0; j < 4; j++) begin
            check("t4_valid", 32'(uplink_valid), 32'h1);
            check("t4_data", 32'(uplink_data), 32'hC000 + 32'(j));
            tick;
        end
        check("t4_end_valid", 32'(uplink_valid), 32'h0);
        check("t4_end_count", 32'(fifo_count), 32'h0);
        // reset while SEND active with 5 queued
        uplink_full = 1; src_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            src_data[15:0] = 16'hD000 + 16'(k);
            tick;
        end
        uplink_full = 0; src_valid = 0; #1;
        check("t5_count6", 32'(fifo_count), 32'h6);
        tick;
        check("t5_send_valid", 32'(uplink_valid), 32'h1);
        check("t5_send_data", 32'(uplink_data), 32'hD000);
        check("t5_count5", 32'(fifo_count), 32'h5);
        reset = 1;
        tick;
        reset = 0; src_valid = 4'hF; #1;
        check("t5_rst_valid", 32'(uplink_valid), 32'h0);
        check("t5_rst_count", 32'(fifo_count), 32'h0);
        check("t5_rst_data", 32'(uplink_data), 32'h0);
        check("t5_rst_rr", 32'(src_ready), 32'h1);
        tick;
        src_valid = 0;
        repeat (4) tick;
        check("t5_quiet_count", 32'(fifo_count), 32'h0);
`ifdef UPLINK_STATS_EN
        reset = 1; tick; reset = 0;
        src_valid = 4'b0100; src_data[47:32] = 16'hE000;
        repeat (70000) tick;
        src_valid = 0;
        repeat (3) tick;
        check("t6_sat", 32'(stat_flits[47:32]), 32'hFFFF);
        check("t6_src0", 32'(stat_flits[15:0]), 32'h0);
        reset = 1; tick; reset = 0; #1;
        check("t6_clr", 32'(stat_flits[47:32]), 32'h0);
        uplink_full = 1; src_valid = 4'b0100;
        tick;
        src_valid = 0;
        repeat (10) tick;
        uplink_full = 0; #1;
        check("t6_stall", 32'(stat_stall_cycles), 32'd10);
        check("t6_one", 32'(stat_flits[47:32]), 32'h1);
        repeat (3) tick;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
